// File: rtl/pl_id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a multi-cycle
// MDU hold sequencer that freezes the front end while an MDU op occupies EX.
module pl_id_ex_stage #(
  parameter int MDU_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_alu_src,
  input  logic        id_is_mdu,
  input  logic [3:0]  id_alu_op,
  input  logic        flush,
  output logic        ID_EX_valid,
  output logic [4:0]  ID_EX_rs,
  output logic [4:0]  ID_EX_rt,
  output logic [4:0]  ID_EX_rd,
  output logic [31:0] ID_EX_rs_data,
  output logic [31:0] ID_EX_rt_data,
  output logic [31:0] ID_EX_imm,
  output logic [31:0] ID_EX_pc,
  output logic        ID_EX_reg_write,
  output logic        ID_EX_mem_read,
  output logic        ID_EX_mem_write,
  output logic        ID_EX_mem_to_reg,
  output logic        ID_EX_alu_src,
  output logic [3:0]  ID_EX_alu_op,
  output logic        ID_EX_is_mdu,
  output logic        stall,
  output logic        ex_hold
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        is_mdu;
  } ex_t;

  typedef enum logic {RUN, MDU_BUSY} state_t;
  typedef enum logic [1:0] {LD_LOAD, LD_HOLD, LD_BUBBLE} ld_t;

  // First RUN cycle with the op in EX already counts, hence LATENCY-2.
  localparam logic [3:0] CNT_INIT = 4'(MDU_LATENCY - 2);

  state_t     r_state, w_next_state;
  logic [3:0] r_cnt, w_next_cnt;
  ex_t        r_ex, w_id;
  ld_t        w_ld;
  logic       w_load_use;

  always_comb begin
    w_id            = '0;
    w_id.valid      = id_valid;
    w_id.rs_data    = id_rs_data;
    w_id.rt_data    = id_rt_data;
    w_id.imm        = id_imm;
    w_id.pc         = id_pc;
    if (id_valid) begin
      w_id.rs         = id_rs;
      w_id.rt         = id_rt;
      w_id.rd         = id_rd;
      w_id.reg_write  = id_reg_write;
      w_id.mem_read   = id_mem_read;
      w_id.mem_write  = id_mem_write;
      w_id.mem_to_reg = id_mem_to_reg;
      w_id.alu_src    = id_alu_src;
      w_id.alu_op     = id_alu_op;
      w_id.is_mdu     = id_is_mdu;
    end
  end

  assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) && id_valid &&
                      ((id_uses_rs && (id_rs == r_ex.rd)) ||
                       (id_uses_rt && (id_rt == r_ex.rd)));

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_ld         = LD_LOAD;
    stall        = 1'b0;
    ex_hold      = 1'b0;
    if (flush) begin
      w_ld         = LD_BUBBLE;
      w_next_state = RUN;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_ex.valid && r_ex.is_mdu) begin
            stall        = 1'b1;
            ex_hold      = 1'b1;
            w_next_state = MDU_BUSY;
            w_next_cnt   = CNT_INIT;
            w_ld         = LD_HOLD;
          end else if (w_load_use) begin
            stall = 1'b1;
            w_ld  = LD_BUBBLE;
          end
        end
        MDU_BUSY: begin
          if (r_cnt != 4'd0) begin
            stall      = 1'b1;
            ex_hold    = 1'b1;
            w_next_cnt = r_cnt - 4'd1;
            w_ld       = LD_HOLD;
          end else begin
            // Release cycle: EX takes the next instruction as in RUN.
            w_next_state = RUN;
            if (w_load_use) begin
              stall = 1'b1;
              w_ld  = LD_BUBBLE;
            end
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_ex    <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_ld == LD_LOAD)        r_ex <= w_id;
      else if (w_ld == LD_BUBBLE) r_ex <= '0;
    end
  end

  assign ID_EX_valid      = r_ex.valid;
  assign ID_EX_rs         = r_ex.rs;
  assign ID_EX_rt         = r_ex.rt;
  assign ID_EX_rd         = r_ex.rd;
  assign ID_EX_rs_data    = r_ex.rs_data;
  assign ID_EX_rt_data    = r_ex.rt_data;
  assign ID_EX_imm        = r_ex.imm;
  assign ID_EX_pc         = r_ex.pc;
  assign ID_EX_reg_write  = r_ex.reg_write;
  assign ID_EX_mem_read   = r_ex.mem_read;
  assign ID_EX_mem_write  = r_ex.mem_write;
  assign ID_EX_mem_to_reg = r_ex.mem_to_reg;
  assign ID_EX_alu_src    = r_ex.alu_src;
  assign ID_EX_alu_op     = r_ex.alu_op;
  assign ID_EX_is_mdu     = r_ex.is_mdu;

endmodule

// File: tb/tb_pl_id_ex_stage.sv
// Directed hazard/MDU/flush/reset scenarios plus randomized traffic checked
// against a cycle-age reference model of the ID/EX stage.
module tb_pl_id_ex_stage;
  localparam int LAT = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        asrc;
    logic [3:0]  aop;
    logic        mdu;
  } ex_t;

  logic clk, rst, flush, uses_rs, uses_rt;
  ex_t  in;
  logic ID_EX_valid, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write;
  logic ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_is_mdu, stall, ex_hold;
  logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_rd;
  logic [31:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc;
  logic [3:0]  ID_EX_alu_op;
  logic [153:0] dut_vec;

  int checks = 0, failures = 0;
  ex_t m;
  int  age;

  pl_id_ex_stage #(.MDU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(in.valid), .id_uses_rs(uses_rs), .id_uses_rt(uses_rt),
    .id_rs(in.rs), .id_rt(in.rt), .id_rd(in.rd),
    .id_rs_data(in.rs_data), .id_rt_data(in.rt_data), .id_imm(in.imm), .id_pc(in.pc),
    .id_reg_write(in.rw), .id_mem_read(in.mr), .id_mem_write(in.mw),
    .id_mem_to_reg(in.m2r), .id_alu_src(in.asrc), .id_is_mdu(in.mdu),
    .id_alu_op(in.aop), .flush(flush),
    .ID_EX_valid(ID_EX_valid), .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd),
    .ID_EX_rs_data(ID_EX_rs_data), .ID_EX_rt_data(ID_EX_rt_data), .ID_EX_imm(ID_EX_imm),
    .ID_EX_pc(ID_EX_pc), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
    .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_is_mdu(ID_EX_is_mdu),
    .stall(stall), .ex_hold(ex_hold)
  );

  assign dut_vec = {ID_EX_valid, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_rs_data, ID_EX_rt_data,
                    ID_EX_imm, ID_EX_pc, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write,
                    ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op, ID_EX_is_mdu};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_t mk(logic [31:0] pc, logic [4:0] rs, logic [4:0] rd,
                             logic mr, logic mdu);
    ex_t r;
    r = '0;
    r.valid = 1'b1; r.pc = pc; r.rs = rs; r.rt = 5'd3; r.rd = rd;
    r.rw = 1'b1; r.mr = mr; r.m2r = mr; r.mdu = mdu; r.aop = 4'h2;
    r.rs_data = 32'h1111_0000 ^ pc; r.rt_data = 32'h2222; r.imm = 32'h10;
    return r;
  endfunction

  function automatic ex_t mload(ex_t x);
    ex_t r;
    r = x;
    if (!x.valid) begin
      r.rs = '0; r.rt = '0; r.rd = '0;
      r.rw = 0; r.mr = 0; r.mw = 0; r.m2r = 0; r.asrc = 0; r.aop = '0; r.mdu = 0;
    end
    return r;
  endfunction

  task automatic test_reset();
    in = mk(32'h200, 5'd1, 5'd5, 1'b0, 1'b1);
    uses_rs = 1; uses_rt = 0; flush = 1; rst = 1;
    tick();
    rst = 0; flush = 0; in = '0;
    checks++;
    if (dut_vec !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", dut_vec); end
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if (ex_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", ex_hold); end
    tick();
  endtask

  task automatic test_load_use();
    in = mk(32'h300, 5'd1, 5'd8, 1'b1, 1'b0); uses_rs = 1;
    tick();
    in = mk(32'h304, 5'd8, 5'd9, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++;
    if (ID_EX_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", ID_EX_valid); end
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", stall); end
    tick();
    checks++;
    if (ID_EX_rs !== 5'd8 || ID_EX_pc !== 32'h304 || ID_EX_valid !== 1'b1) begin
      failures++; $display("FAIL lu_advance got rs=%0d pc=%h exp rs=8 pc=304", ID_EX_rs, ID_EX_pc);
    end
  endtask

  task automatic test_r0();
    in = mk(32'h400, 5'd1, 5'd0, 1'b1, 1'b0); uses_rs = 1;
    tick();
    in = mk(32'h404, 5'd0, 5'd9, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", stall); end
    tick();
    checks++;
    if (ID_EX_pc !== 32'h404) begin failures++; $display("FAIL r0_advance got=%h exp=404", ID_EX_pc); end
  endtask

  task automatic test_mdu();
    in = mk(32'h100, 5'd1, 5'd5, 1'b0, 1'b1); uses_rs = 1;
    tick();
    in = mk(32'h104, 5'd2, 5'd6, 1'b0, 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      #1;
      checks++;
      if (stall !== (k < LAT) || ex_hold !== (k < LAT)) begin
        failures++;
        $display("FAIL mdu_cycle%0d got stall=%b hold=%b exp=%b", k, stall, ex_hold, k < LAT);
      end
      checks++;
      if (ID_EX_pc !== 32'h100) begin failures++; $display("FAIL mdu_pc%0d got=%h exp=100", k, ID_EX_pc); end
      tick();
    end
    checks++;
    if (ID_EX_pc !== 32'h104) begin failures++; $display("FAIL mdu_next got=%h exp=104", ID_EX_pc); end
  endtask

  task automatic test_flush_mdu();
    in = mk(32'h500, 5'd1, 5'd5, 1'b0, 1'b1);
    tick();
    in = mk(32'h504, 5'd2, 5'd6, 1'b0, 1'b0);
    tick();
    tick();
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || ex_hold !== 1'b0) begin
      failures++; $display("FAIL flush_mdu_comb got stall=%b hold=%b exp=0", stall, ex_hold);
    end
    tick();
    flush = 0;
    checks++;
    if (ID_EX_valid !== 1'b0) begin failures++; $display("FAIL flush_mdu_bubble got=%b exp=0", ID_EX_valid); end
    tick();
    checks++;
    if (ID_EX_pc !== 32'h504) begin failures++; $display("FAIL flush_mdu_run got=%h exp=504", ID_EX_pc); end
  endtask

  task automatic test_flush_loaduse();
    in = mk(32'h600, 5'd1, 5'd8, 1'b1, 1'b0); uses_rs = 1;
    tick();
    in = mk(32'h604, 5'd8, 5'd9, 1'b0, 1'b0);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_lu_stall got=%b exp=0", stall); end
    tick();
    flush = 0;
    checks++;
    if (ID_EX_valid !== 1'b0) begin failures++; $display("FAIL flush_lu_bubble got=%b exp=0", ID_EX_valid); end
    tick();
    checks++;
    if (ID_EX_valid !== 1'b1 || ID_EX_rs !== 5'd8) begin
      failures++; $display("FAIL flush_lu_load got v=%b rs=%0d exp v=1 rs=8", ID_EX_valid, ID_EX_rs);
    end
  endtask

  task automatic test_rst_mdu();
    in = mk(32'h700, 5'd1, 5'd5, 1'b0, 1'b1);
    tick();
    in = mk(32'h704, 5'd2, 5'd7, 1'b0, 1'b0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (dut_vec !== '0) begin failures++; $display("FAIL rst_mdu_regs got=%h exp=0", dut_vec); end
    #1;
    checks++;
    if (stall !== 1'b0 || ex_hold !== 1'b0) begin
      failures++; $display("FAIL rst_mdu_comb got stall=%b hold=%b exp=0", stall, ex_hold);
    end
    tick();
  endtask

  task automatic test_random();
    logic hold, lu;
    rst = 1; flush = 0; in = '0;
    tick();
    rst = 0; m = '0; age = 1;
    for (int n = 0; n < 800; n++) begin
      in.valid   = ($urandom_range(0, 9) != 0);
      in.rs      = 5'($urandom_range(0, 3));
      in.rt      = 5'($urandom_range(0, 3));
      in.rd      = 5'($urandom_range(0, 3));
      in.rs_data = $urandom; in.rt_data = $urandom; in.imm = $urandom; in.pc = $urandom;
      in.mdu     = ($urandom_range(0, 9) == 0);
      in.mr      = !in.mdu && ($urandom_range(0, 2) == 0);
      in.rw = 1'($urandom); in.mw = 1'($urandom); in.m2r = 1'($urandom);
      in.asrc = 1'($urandom); in.aop = 4'($urandom);
      uses_rs = 1'($urandom); uses_rt = 1'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      #1;
      hold = m.valid && m.mdu && (age < LAT);
      lu   = m.valid && m.mr && (m.rd != 0) && in.valid &&
             ((uses_rs && in.rs == m.rd) || (uses_rt && in.rt == m.rd));
      if (!rst) begin
        checks++;
        if (stall !== (!flush && (hold || lu)) || ex_hold !== (!flush && hold)) begin
          failures++;
          $display("FAIL rnd_comb n=%0d got stall=%b hold=%b exp stall=%b hold=%b",
                   n, stall, ex_hold, !flush && (hold || lu), !flush && hold);
        end
      end
      @(posedge clk);
      if (rst || flush)  begin m = '0; age = 1; end
      else if (hold)     age++;
      else if (lu)       begin m = '0; age = 1; end
      else               begin m = mload(in); age = 1; end
      #1;
      checks++;
      if (dut_vec !== m) begin
        failures++; $display("FAIL rnd_regs n=%0d got=%h exp=%h", n, dut_vec, m);
      end
    end
    rst = 0; flush = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in = '0; uses_rs = 0; uses_rt = 0;
    test_reset();
    test_load_use();
    test_r0();
    test_mdu();
    test_flush_mdu();
    test_flush_loaduse();
    test_rst_mdu();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
